mac_neuron_vec: RTL

MAC_NEURON_VEC -- requirements
Module: mac_neuron_vec

---
 rtl/mac_neuron_vec.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mac_neuron_vec.sv
// mac_neuron_vec: single-neuron multiply-accumulate with bias, optional ReLU and
// saturation to the output width.
//
// One evaluation consumes LEN signed x*w terms:
//   IDLE  --start-->  ACCUM (acc = bias)  --LEN terms-->  OUTPUT (1 cycle)  -->  IDLE
// y/ovf/done_out are loaded on the OUTPUT->IDLE edge; done_out pulses for one cycle.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : begin an evaluation (accepted only in IDLE)
//   bias      : signed OUT_W bias, sampled with start
//   relu_en   : ReLU select, sampled with start
//   in_valid  : x/w pair valid
//   x, w      : signed DATA_W activation / weight
//   in_ready  : a term is accepted this cycle when in_valid is high
//   busy      : evaluation in progress
//   acc       : signed ACC_W raw accumulator
//   y         : signed OUT_W activated, saturated result
//   ovf       : y was saturated on the last evaluation
//   done_out  : one-cycle pulse when y is valid
module mac_neuron_vec #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int OUT_W  = 16,
   parameter int LEN    = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [OUT_W-1:0]  bias,
   input  logic                     relu_en,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] w,
   output logic                     in_ready,
   output logic                     busy,
   output logic signed [ACC_W-1:0]  acc,
   output logic signed [OUT_W-1:0]  y,
   output logic                     ovf,
   output logic                     done_out
);

   localparam int CNT_W = $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(LEN - 1);

   // Output range expressed at accumulator width for the clamp compare.
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {StIdle, StAccum, StOutput} state_e;

   state_e                    r_state;
   logic [CNT_W-1:0]          r_count;
   logic                      r_relu;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [OUT_W-1:0]   r_y;
   logic                      r_ovf;
   logic                      r_done;

   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]    w_prod_ext;
   logic signed [ACC_W-1:0]    w_bias_ext;
   logic                       w_accept;
   logic signed [OUT_W-1:0]    w_y_next;
   logic                       w_ovf_next;

   // Operands are sign-extended before the multiply so the full product is kept.
   assign w_prod     = (2*DATA_W)'(x) * (2*DATA_W)'(w);
   assign w_prod_ext = ACC_W'(w_prod);
   assign w_bias_ext = ACC_W'(bias);
   assign w_accept   = in_valid && (r_state == StAccum);

   // Activation and saturation of the finished sum.
   always_comb begin
      w_y_next   = r_acc[OUT_W-1:0];
      w_ovf_next = 1'b0;
      if (r_relu && r_acc[ACC_W-1]) begin
         w_y_next = '0;
      end else if (r_acc > SAT_MAX) begin
         w_y_next   = SAT_MAX[OUT_W-1:0];
         w_ovf_next = 1'b1;
      end else if (r_acc < SAT_MIN) begin
         w_y_next   = SAT_MIN[OUT_W-1:0];
         w_ovf_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_count <= '0;
         r_relu  <= 1'b0;
         r_acc   <= '0;
         r_y     <= '0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_state <= StAccum;
                  r_acc   <= w_bias_ext;
                  r_count <= '0;
                  r_relu  <= relu_en;
               end
            end
            StAccum: begin
               if (w_accept) begin
                  r_acc   <= r_acc + w_prod_ext;
                  r_count <= r_count + CNT_W'(1);
                  if (r_count == LAST_TERM) begin
                     r_state <= StOutput;
                  end
               end
            end
            StOutput: begin
               r_state <= StIdle;
               r_y     <= w_y_next;
               r_ovf   <= w_ovf_next;
               r_done  <= 1'b1;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign in_ready = (r_state == StAccum);
   assign busy     = (r_state != StIdle);
   assign acc      = r_acc;
   assign y        = r_y;
   assign ovf      = r_ovf;
   assign done_out = r_done;

endmodule
